// File: rtl/stopwatch_display_scheduler.sv
// Frame scheduler: snapshots the channel bank, runs each channel through the shared
// binary-to-BCD encoder and scans tens/ones onto a multiplexed display. Option: BLANK_LEADING_ZERO_EN.
module stopwatch_display_scheduler #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [4*N_CH-1:0]   ch_value,
    input  logic                freeze,
    output logic [3:0]          enc_in,
    input  logic                enc_tens,
    input  logic [3:0]          enc_ones,
    output logic [2*N_CH-1:0]   digit_sel,
    output logic [3:0]          digit_bcd,
    output logic                blank,
    output logic                frame_done,
    output logic                enc_err
);

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned DW_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(SCAN_DIV - 1);
    localparam logic [CH_W-1:0] CH_LAST    = CH_W'(N_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNAP,
        S_LOAD,
        S_CAPTURE,
        S_TENS,
        S_ONES
    } state_t;

    state_t            state, state_d;
    logic [3:0]        snap [N_CH];
    logic              snap_valid;
    logic [CH_W-1:0]   ch;
    logic [DW_W-1:0]   dwell;
    logic              dwell_done;

    logic              cap_tens;
    logic [3:0]        cap_ones;
    logic              cap_bad;

    logic [3:0]        cur_val;
    logic              enc_fault;
    logic              new_tens;
    logic [3:0]        new_ones;
    logic              show_tens;
    logic              show_bad;

    logic [2*N_CH-1:0] sel_d;
    logic [3:0]        bcd_d;
    logic              blank_d;
    logic              done_d;

    assign dwell_done = (dwell == '0);

    always_comb begin
        cur_val   = snap[ch];
        enc_fault = (enc_ones > 4'd9) || (enc_tens && (cur_val < 4'd10));
        new_tens  = enc_fault ? 1'b0 : enc_tens;
        new_ones  = enc_fault ? 4'd0 : enc_ones;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Output registers are loaded from the next state so they line up with the FSM cycle.
    always_comb begin
        state_d   = state;
        sel_d     = '0;
        bcd_d     = '0;
        blank_d   = 1'b1;
        done_d    = 1'b0;
        show_tens = (state == S_CAPTURE) ? new_tens  : cap_tens;
        show_bad  = (state == S_CAPTURE) ? enc_fault : cap_bad;

        case (state)
            S_IDLE:    state_d = S_SNAP;
            S_SNAP:    state_d = S_LOAD;
            S_LOAD:    state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_TENS;
            S_TENS:    if (dwell_done) state_d = S_ONES;
            S_ONES:    if (dwell_done) state_d = (ch == CH_LAST) ? S_SNAP : S_LOAD;
            default:   state_d = S_IDLE;
        endcase

        case (state_d)
            S_SNAP: done_d = (state == S_ONES);
            S_TENS: begin
                sel_d[{ch, 1'b0}] = 1'b1;
                bcd_d             = {3'b000, show_tens};
`ifdef BLANK_LEADING_ZERO_EN
                blank_d           = show_bad || !show_tens;
`else
                blank_d           = show_bad;
`endif
            end
            S_ONES: begin
                sel_d[{ch, 1'b1}] = 1'b1;
                bcd_d             = cap_ones;
                blank_d           = cap_bad;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_CH; i++) snap[i] <= '0;
            snap_valid <= 1'b0;
            ch         <= '0;
            dwell      <= '0;
            enc_in     <= '0;
            cap_tens   <= 1'b0;
            cap_ones   <= '0;
            cap_bad    <= 1'b0;
            enc_err    <= 1'b0;
            digit_sel  <= '0;
            digit_bcd  <= '0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            if (state == S_SNAP) begin
                ch <= '0;
                if (!freeze || !snap_valid) begin
                    for (int unsigned i = 0; i < N_CH; i++) snap[i] <= ch_value[4*i +: 4];
                    snap_valid <= 1'b1;
                end
            end

            if (state == S_LOAD) enc_in <= snap[ch];

            if (state == S_CAPTURE) begin
                cap_tens <= new_tens;
                cap_ones <= new_ones;
                cap_bad  <= enc_fault;
                if (enc_fault) enc_err <= 1'b1;
            end

            if (state == S_ONES && dwell_done && ch != CH_LAST) ch <= ch + 1'b1;

            if (state == S_CAPTURE || (state == S_TENS && dwell_done)) begin
                dwell <= DWELL_LOAD;
            end else if (!dwell_done) begin
                dwell <= dwell - 1'b1;
            end

            digit_sel  <= sel_d;
            digit_bcd  <= bcd_d;
            blank      <= blank_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: doc/stopwatch_display_scheduler.md
# stopwatch_display_scheduler

- Sequences the shared combinational binary-to-BCD encoder across the stopwatch's binary digit counters.
- Time-multiplexes the result onto a scanned seven-segment display.
- Each frame does the following:
  - snapshots all channel values;
  - feeds each channel in turn to the encoder;
  - captures the tens/ones result;
  - scans the two resulting digits out.
- Sits between the stopwatch counter bank and the seven-segment decoder/anode drivers.

## Interface
Parameters:
- N_CH, 4, number of 4-bit binary channels (1..8)
- SCAN_DIV, 1000, clock cycles each digit is lit (>=1)

Ports:
- clock  in  1  system clock, all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- ch_value  in  4*N_CH  channel k value on bits [4k+3:4k], binary 0..15
- freeze  in  1  lap hold; sampled only in SNAP
- enc_in  out  4  binary operand to shared encoder, registered
- enc_tens  in  1  encoder tens bit
- enc_ones  in  4  encoder ones digit
- digit_sel  out  2*N_CH  one-hot anode select, active-high; bit 2k = channel k tens, bit 2k+1 = channel k ones
- digit_bcd  out  4  BCD digit for the lit position
- blank  out  1  1 = segments off
- frame_done  out  1  one-cycle pulse at end of frame
- enc_err  out  1  sticky encoder plausibility error

## Operation
- State machine: IDLE -> SNAP -> LOAD -> CAPTURE -> TENS -> ONES -> (LOAD for next channel | SNAP after last channel).
- IDLE:
  - Entered only from reset.
  - Leaves on the first clock after reset_n deasserts.
- SNAP:
  - If freeze=0, or no snapshot has yet been taken since reset, copy ch_value into the snapshot register.
  - If freeze=1 and a snapshot exists, keep the old snapshot.
  - Channel index ch := 0.
- LOAD:
  - enc_in := snapshot[ch].
- CAPTURE:
  - Register {enc_tens, enc_ones}; enc_in is stable for the whole cycle.
  - If enc_ones > 9, or if enc_tens=1 and snapshot[ch] < 10:
    - set enc_err;
    - the captured digit is forced to 0 with blank=1 for both digits of that channel.
- TENS:
  - digit_sel = bit 2ch.
  - digit_bcd = {3'b000, tens}.
  - blank=0, except when leading-zero blanking applies (see Configuration).
  - Held for SCAN_DIV cycles.
- ONES:
  - digit_sel = bit 2ch+1.
  - digit_bcd = ones, blank=0.
  - Held for SCAN_DIV cycles.
  - On exit:
    - if ch = N_CH-1, pulse frame_done and go to SNAP;
    - otherwise ch := ch+1 and go to LOAD.
- In IDLE, SNAP, LOAD and CAPTURE: digit_sel=0 and blank=1. This inter-digit gap prevents ghosting.
- The dwell counter is ceil(log2(SCAN_DIV)) bits. It reloads on entry to TENS/ONES and counts SCAN_DIV-1 down to 0.
- enc_err clears only on reset.
- The ch_value input is never used directly for display; only the snapshot is.

## Timing
- All outputs are registered and change only on clock rising edges or on reset.
- Reset values:
  - enc_in=0, digit_sel=0, digit_bcd=0, blank=1;
  - frame_done=0, enc_err=0;
  - snapshot invalid, state IDLE.
- Asynchronous reset mid-frame: all outputs go to reset values immediately.
  - After release, the next frame starts from SNAP with a fresh snapshot; freeze is ignored there because no snapshot exists.
- Per channel: 2 + 2*SCAN_DIV cycles. Per frame: N_CH*(2+2*SCAN_DIV) + 1 cycles (the +1 is SNAP).
- Latency from channel value to its display:
  - the value is visible in TENS 3 cycles after the SNAP edge for ch 0;
  - channel k waits an additional k*(2+2*SCAN_DIV) cycles.
- frame_done is asserted during the cycle the FSM occupies SNAP after the last ONES. It is never asserted for the first SNAP after reset.
- freeze changes outside SNAP have no effect until the next SNAP.
- A freeze release takes effect at the next frame boundary.
- Wrap-around: ch returns 0 after N_CH-1. N_CH=1 is legal and visits the single channel every frame.
- Inputs at maximum: ch_value=15 gives tens=1, ones=5. No saturation or clipping is performed; 4-bit input cannot exceed 15.

## Configuration
- BLANK_LEADING_ZERO_EN defined: in TENS, if the captured tens=0, blank=1. digit_sel and digit_bcd still drive normally, with digit_bcd=0.
- Not defined: the tens digit is always shown; blank=0 in TENS unless enc_err blanking applies.
- Scan timing is identical in both builds.

## Test plan
Bench uses N_CH=4, SCAN_DIV=4 and a correct behavioural encoder.
- Reset behaviour:
  - Stimulus: hold reset_n=0 for 5 cycles, then release.
  - Required: outputs at reset values during reset; IDLE->SNAP->LOAD occurs; TENS for ch 0 appears 3 cycles after release+1.
- Full-frame scan:
  - Stimulus: ch_value={4'd15,4'd9,4'd10,4'd3}.
  - Required scan sequence: ch0 tens 0 / ones 3, ch1 1/0, ch2 0/9, ch3 1/5. Each digit lit exactly 4 cycles with 2 blank cycles between channels.
  - Required: frame_done pulses once after 41 cycles.
- Freeze:
  - Stimulus: assert freeze, then change ch_value to all 7s mid-frame.
  - Required: the following frame still shows the old snapshot.
  - Stimulus: deassert freeze.
  - Required: the frame after the next SNAP shows 0/7 for every channel.
- Encoder fault:
  - Stimulus: force enc_ones=4'd12 during ch 2 CAPTURE.
  - Required: enc_err rises next cycle and stays 1; ch 2 is blanked for both digits; other channels are unaffected.
- Leading-zero blanking (build with BLANK_LEADING_ZERO_EN):
  - Stimulus: ch value 3.
  - Required: TENS has blank=1, ONES shows 3 with blank=0.
  - Stimulus: value 12.
  - Required: tens is shown as 1.
- Reset mid-frame:
  - Stimulus: pulse reset_n low during ch 2 ONES.
  - Required: digit_sel=0 and blank=1 immediately; enc_err cleared; restart at SNAP with freeze ignored.
